// File: rtl/int_div_pkg.sv
// int_div_pkg -- shared types and helpers for the sequential integer divider.
//
// Contents:
//   div_state_e : controller states (IDLE, PREP, CALC, FIX, DONE)
//   cnt_width() : width of the iteration counter for a given operand width
package int_div_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

    // Counter must be able to hold 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/int_div_step.sv
// int_div_step -- one combinational radix-2 restoring division iteration.
//
// The pair {rem, quo} is shifted left by one, pulling the next dividend bit
// (quo MSB) into the partial remainder. The divisor magnitude is then
// trial-subtracted with a WIDTH+1-bit subtractor; a non-negative difference
// is kept and a 1 is shifted into the quotient, otherwise the shifted
// remainder is restored and a 0 is shifted in.
//
// Ports:
//   rem         : current partial remainder (always < divisor_mag)
//   quo         : quotient bits so far in the low part, unconsumed dividend
//                 bits in the high part
//   divisor_mag : unsigned divisor magnitude
//   next_rem    : partial remainder after this step
//   next_quo    : quotient/dividend register after this step
module int_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           negative;

    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor_mag};
    assign negative = diff[WIDTH];

    always_comb begin
        next_quo = {quo[WIDTH-2:0], ~negative};
        next_rem = '0;
        if (negative) begin
            next_rem = shifted[WIDTH-1:0];
        end else begin
            // rem < divisor_mag on entry, so the difference fits in WIDTH bits.
            next_rem = diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/int_div_seq.sv
// int_div_seq -- multi-cycle radix-2 restoring integer divider.
//
// Computes quotient and remainder of dividend/divisor, unsigned or signed
// (truncating toward zero, remainder takes the dividend's sign). Division by
// zero and signed MIN/-1 produce RISC-V style results and raise a flag.
// Latency is fixed at WIDTH+2 edges from accept to out_valid.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready only in IDLE)
//   in_signed           : signed operation (ignored when SIGNED_EN == 0)
//   dividend, divisor   : operands, sampled at accept
//   out_valid/out_ready : result handshake, result held until consumed
//   quotient, remainder : results
//   div_by_zero         : divisor was zero
//   overflow            : signed MIN / -1
//   busy                : any state other than IDLE
module int_div_seq
    import int_div_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             busy
);

    localparam int                 CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q;
    div_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;

    // Captured operands and mode.
    logic [WIDTH-1:0] a_raw_q;
    logic [WIDTH-1:0] b_raw_q;
    logic             sgn_q;

    // Working registers.
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] b_mag_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             dz_q;
    logic             ovf_q;

    // Combinational helpers.
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;

    int_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem        (rem_q),
        .quo        (quo_q),
        .divisor_mag(b_mag_q),
        .next_rem   (step_rem),
        .next_quo   (step_quo)
    );

    // Operand magnitudes; the magnitude of MIN is MIN itself read unsigned.
    always_comb begin
        sign_a = sgn_q & a_raw_q[WIDTH-1];
        sign_b = sgn_q & b_raw_q[WIDTH-1];
        a_abs  = sign_a ? (~a_raw_q + 1'b1) : a_raw_q;
        b_abs  = sign_b ? (~b_raw_q + 1'b1) : b_raw_q;
    end

    // Sign correction followed by special-case substitution.
    always_comb begin
        fix_q = q_neg_q ? (~quo_q + 1'b1) : quo_q;
        fix_r = r_neg_q ? (~rem_q + 1'b1) : rem_q;
        if (dz_q) begin
            fix_q = '1;
            fix_r = a_raw_q;
        end else if (ovf_q) begin
            fix_q = MIN_VAL;
            fix_r = '0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d = PREP;
                end
            end
            PREP: begin
                state_d = CALC;
            end
            CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            a_raw_q     <= '0;
            b_raw_q     <= '0;
            sgn_q       <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            b_mag_q     <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_raw_q <= dividend;
                        b_raw_q <= divisor;
                        sgn_q   <= SIGNED_EN && in_signed;
                    end
                end
                PREP: begin
                    cnt_q   <= '0;
                    rem_q   <= '0;
                    quo_q   <= a_abs;
                    b_mag_q <= b_abs;
                    q_neg_q <= sign_a ^ sign_b;
                    r_neg_q <= sign_a;
                    dz_q    <= (b_raw_q == '0);
                    ovf_q   <= sgn_q && (a_raw_q == MIN_VAL) && (b_raw_q == '1);
                end
                CALC: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    quotient    <= fix_q;
                    remainder   <= fix_r;
                    div_by_zero <= dz_q;
                    overflow    <= ovf_q & ~dz_q;
                    cnt_q       <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_div_seq.sv
// tb_int_div_seq -- self-checking bench for int_div_seq at WIDTH=8.
module tb_int_div_seq;

    localparam int             W   = 8;
    localparam logic [W-1:0]   MIN = {1'b1, {(W-1){1'b0}}};

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } res_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;
    logic         busy;

    int   checks = 0;
    int   errors = 0;
    res_t scb[$];

    int_div_seq #(
        .WIDTH    (W),
        .SIGNED_EN(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_signed  (in_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model built on the simulator's own integer division.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s);
        res_t m;
        int   sa;
        int   sbv;
        int   qi;
        int   ri;
        m = '0;
        if (b == '0) begin
            m.q  = '1;
            m.r  = a;
            m.dz = 1'b1;
        end else if (s && a == MIN && b == '1) begin
            m.q  = MIN;
            m.r  = '0;
            m.ov = 1'b1;
        end else if (s) begin
            sa  = $signed(a);
            sbv = $signed(b);
            qi  = sa / sbv;
            ri  = sa % sbv;
            m.q = qi[W-1:0];
            m.r = ri[W-1:0];
        end else begin
            m.q = a / b;
            m.r = a % b;
        end
        return m;
    endfunction

    function automatic res_t dut_res();
        return {quotient, remainder, div_by_zero, overflow};
    endfunction

    function automatic string fmt(input res_t v);
        return $sformatf("q=%h r=%h dz=%b ov=%b", v.q, v.r, v.dz, v.ov);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation, wait for the accept edge, record the expectation.
    task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic s);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        dividend  = a;
        divisor   = b;
        in_signed = s;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        scb.push_back(model(a, b, s));
    endtask

    // Number of edges from the current point until out_valid; -1 on timeout.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid) n = -1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     in_ready, out_valid, busy);
        end
        checks++;
        if (dut_res() !== res_t'('0)) begin
            errors++;
            $display("FAIL reset_outputs: got %s required all zero", fmt(dut_res()));
        end
    endtask

    task automatic test_basic();
        int   n;
        res_t e;
        out_ready = 1'b1;
        accept_op(8'd200, 8'd7, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: in_ready=%b busy=%b required 0 1", in_ready, busy);
        end
        wait_valid(n);
        checks++;
        if (n !== W + 2) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges required %0d", n, W + 2);
        end
        e = scb.pop_front();
        checks++;
        if (dut_res() !== e || e.q !== 8'd28 || e.r !== 8'd4) begin
            errors++;
            $display("FAIL basic_200_7: got %s required %s", fmt(dut_res()), fmt(e));
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: out_valid=%b in_ready=%b required 0 1",
                     out_valid, in_ready);
        end
    endtask

    // Directed table: signed/unsigned corners, divide by zero, overflow.
    task automatic test_directed();
        logic [W-1:0] ta [8] = '{8'hF9, 8'h07, 8'hF9, 8'h55, 8'h80, 8'h80, 8'h80, 8'h81};
        logic [W-1:0] tb [8] = '{8'h02, 8'hFE, 8'h02, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF};
        logic         ts [8] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
        logic [W-1:0] xq [8] = '{8'hFD, 8'hFD, 8'h7C, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h7F};
        logic [W-1:0] xr [8] = '{8'hFF, 8'h01, 8'h01, 8'h55, 8'h80, 8'h00, 8'h80, 8'h00};
        int   n;
        res_t e;
        res_t g;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            accept_op(ta[i], tb[i], ts[i]);
            wait_valid(n);
            e = scb.pop_front();
            g = dut_res();
            checks++;
            if (n !== W + 2) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d edges required %0d", i, n, W + 2);
            end
            checks++;
            if (g !== e || g.q !== xq[i] || g.r !== xr[i]) begin
                errors++;
                $display("FAIL directed[%0d] %h/%h s=%b: got %s required %s (q=%h r=%h)",
                         i, ta[i], tb[i], ts[i], fmt(g), fmt(e), xq[i], xr[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int   n;
        int   bad = 0;
        res_t e;
        out_ready = 1'b0;
        accept_op(8'hE3, 8'h05, 1'b1);
        wait_valid(n);
        e = scb.pop_front();
        for (int i = 0; i < 20; i++) begin
            if (dut_res() !== e || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
            dividend  = 8'($urandom);
            divisor   = 8'($urandom);
            in_signed = 1'($urandom);
            in_valid  = (i % 2 == 1);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0 || n !== W + 2) begin
            errors++;
            $display("FAIL backpressure_hold: %0d unstable cycles, latency %0d, got %s required %s",
                     bad, n, fmt(dut_res()), fmt(e));
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_res() !== e) begin
            errors++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b %s required 0 1 %s",
                     out_valid, in_ready, fmt(dut_res()), fmt(e));
        end
        accept_op(8'h64, 8'h09, 1'b0);
        wait_valid(n);
        e = scb.pop_front();
        checks++;
        if (dut_res() !== e || n !== W + 2) begin
            errors++;
            $display("FAIL backpressure_next: got %s lat %0d required %s lat %0d",
                     fmt(dut_res()), n, fmt(e), W + 2);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int   n;
        int   stray = 0;
        res_t e;
        out_ready = 1'b1;
        accept_op(8'd100, 8'd3, 1'b0);
        void'(scb.pop_back());
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            dut_res() !== res_t'('0)) begin
            errors++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b busy=%b %s required 0 1 0 zeros",
                     out_valid, in_ready, busy, fmt(dut_res()));
        end
        for (int i = 0; i < 15; i++) begin
            if (out_valid !== 1'b0) stray++;
            tick();
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL reset_mid_stale: out_valid seen %0d times required 0", stray);
        end
        accept_op(8'h9C, 8'h0B, 1'b1);
        wait_valid(n);
        e = scb.pop_front();
        checks++;
        if (dut_res() !== e || n !== W + 2) begin
            errors++;
            $display("FAIL reset_mid_after: got %s lat %0d required %s lat %0d",
                     fmt(dut_res()), n, fmt(e), W + 2);
        end
        tick();
    endtask

    task automatic test_random(input logic s, input int count);
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           sel;
        int           n;
        res_t         e;
        out_ready = 1'b1;
        for (int i = 0; i < count; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            sel = $urandom_range(0, 15);
            if (sel == 0) b = '0;
            if (sel == 1) begin
                a = MIN;
                b = '1;
            end
            if (sel == 2) b = 8'd1;
            accept_op(a, b, s);
            wait_valid(n);
            e = scb.pop_front();
            checks++;
            if (dut_res() !== e || n !== W + 2) begin
                errors++;
                $display("FAIL random s=%b %h/%h: got %s lat %0d required %s lat %0d",
                         s, a, b, fmt(dut_res()), n, fmt(e), W + 2);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random(1'b0, 1000);
        test_random(1'b1, 1000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
